// File: rtl/regfile_write_queue.sv
// In-order write-back queue feeding the register file write port.
// Ports: clk/reset; wb_* handshake in; Write_* registered port out;
//        Read_register*/Bypass_* combinational lookup; wb_count occupancy.
module regfile_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [4:0]               wb_reg,
  input  logic [31:0]              wb_data,
  input  logic                     rf_stall,
  output logic                     Write_enable,
  output logic [4:0]               Write_register,
  output logic [31:0]              Write_data,
  input  logic [4:0]               Read_register1,
  input  logic [4:0]               Read_register2,
  output logic                     Bypass_hit1,
  output logic [31:0]              Bypass_data1,
  output logic                     Bypass_hit2,
  output logic [31:0]              Bypass_data2,
  output logic [$clog2(DEPTH):0]   wb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    reg_q [DEPTH];
  logic [31:0]   dat_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [4:0]    wr_q, wr_d;
  logic [31:0]   wd_q, wd_d;
  logic          push, pop;

  assign wb_ready       = (cnt_q < CW'(DEPTH));
  assign wb_count       = cnt_q;
  assign Write_enable   = we_q;
  assign Write_register = wr_q;
  assign Write_data     = wd_q;

  // Register 0 requests complete the handshake but never enter the queue.
  assign push = wb_valid && wb_ready && (wb_reg != 5'd0);
  assign pop  = (cnt_q != '0) && !rf_stall;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    we_d   = 1'b0;
    wr_d   = wr_q;
    wd_d   = wd_q;
    if (pop) begin
      we_d   = 1'b1;
      wr_d   = reg_q[head_q];
      wd_d   = dat_q[head_q];
      head_d = head_q + 1'b1;
    end
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      wr_q   <= '0;
      wd_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      wr_q   <= wr_d;
      wd_q   <= wd_d;
    end
  end

  // Storage needs no reset: validity comes from the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[tail_q] <= wb_reg;
      dat_q[tail_q] <= wb_data;
    end
  end

  // Scan oldest to youngest so the youngest match wins; the output
  // stage is the oldest pending write and is checked first.
  function automatic logic [32:0] lookup(input logic [4:0] a);
    logic          hit;
    logic [31:0]   d;
    logic [PW-1:0] idx;
    hit = 1'b0;
    d   = '0;
    if (we_q && (wr_q == a)) begin
      hit = 1'b1;
      d   = wd_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < cnt_q) && (reg_q[idx] == a)) begin
        hit = 1'b1;
        d   = dat_q[idx];
      end
    end
    if (a == 5'd0) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  always_comb begin
    {Bypass_hit1, Bypass_data1} = lookup(Read_register1);
    {Bypass_hit2, Bypass_data2} = lookup(Read_register2);
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed cases plus
// random traffic compared against a queue-based reference model.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        rf_stall;
  logic        Write_enable;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [4:0]  Read_register1;
  logic [4:0]  Read_register2;
  logic        Bypass_hit1;
  logic [31:0] Bypass_data1;
  logic        Bypass_hit2;
  logic [31:0] Bypass_data2;
  logic [2:0]  wb_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [36:0] mq[$];
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  regfile_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_stall(rf_stall),
    .Write_enable(Write_enable),
    .Write_register(Write_register),
    .Write_data(Write_data),
    .Read_register1(Read_register1),
    .Read_register2(Read_register2),
    .Bypass_hit1(Bypass_hit1), .Bypass_data1(Bypass_data1),
    .Bypass_hit2(Bypass_hit2), .Bypass_data2(Bypass_data2),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Youngest pending write wins; committed output stage is oldest.
  function automatic logic [32:0] mlook(input logic [4:0] a);
    if (a == 5'd0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i][36:32] == a) return {1'b1, mq[i][31:0]};
    if (m_we && m_wr == a) return {1'b1, m_wd};
    return 33'd0;
  endfunction

  task automatic model_edge();
    logic acc;
    if (reset) begin
      mq.delete();
      m_we = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      acc = wb_valid && (mq.size() < DEPTH);
      if (mq.size() > 0 && !rf_stall) begin
        m_we = 1'b1;
        m_wr = mq[0][36:32];
        m_wd = mq[0][31:0];
        void'(mq.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (acc && wb_reg != 5'd0) mq.push_back({wb_reg, wb_data});
    end
  endtask

  task automatic cycle();
    logic [32:0] b1, b2;
    @(negedge clk);
    b1 = mlook(Read_register1);
    b2 = mlook(Read_register2);
    chk("wb_ready", 32'(wb_ready), 32'(mq.size() < DEPTH));
    chk("wb_count", 32'(wb_count), 32'(mq.size()));
    chk("we", 32'(Write_enable), 32'(m_we));
    chk("wreg", 32'(Write_register), 32'(m_wr));
    chk("wdata", Write_data, m_wd);
    chk("hit1", 32'(Bypass_hit1), 32'(b1[32]));
    chk("bdata1", Bypass_data1, b1[31:0]);
    chk("hit2", 32'(Bypass_hit2), 32'(b2[32]));
    chk("bdata2", Bypass_data2, b2[31:0]);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb_valid = 1'b0;
    wb_reg = '0;
    wb_data = '0;
    rf_stall = 1'b0;
    Read_register1 = '0;
    Read_register2 = '0;
    m_we = 1'b0;
    m_wr = '0;
    m_wd = '0;
    @(posedge clk);
    model_edge();
    #1;
    cycle();
    reset = 1'b0;
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_count", 32'(wb_count), 32'd0);
    chk("rst_we", 32'(Write_enable), 32'd0);

    // Single write latency
    Read_register1 = 5'd5;
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
    cycle();
    wb_valid = 1'b0;
    chk("single_hit", 32'(Bypass_hit1), 32'd1);
    cycle();
    chk("single_we", 32'(Write_enable), 32'd1);
    chk("single_reg", 32'(Write_register), 32'd5);
    chk("single_data", Write_data, 32'hDEADBEEF);
    chk("single_cnt", 32'(wb_count), 32'd0);
    cycle();
    chk("single_done", 32'(Write_enable), 32'd0);
    chk("single_nohit", 32'(Bypass_hit1), 32'd0);

    // Fill under stall, fifth request held off
    rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1; wb_reg = 5'(i); wb_data = 32'(i);
      cycle();
    end
    wb_reg = 5'd9; wb_data = 32'h99;
    cycle();
    chk("full_cnt", 32'(wb_count), 32'd4);
    chk("full_ready", 32'(wb_ready), 32'd0);
    wb_valid = 1'b0;
    rf_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk("drain_we", 32'(Write_enable), 32'd1);
      chk("drain_order", 32'(Write_register), 32'(i));
    end
    cycle();

    // Register 0 is discarded
    Read_register1 = 5'd0;
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFFFFFF;
    chk("r0_ready", 32'(wb_ready), 32'd1);
    cycle();
    wb_valid = 1'b0;
    chk("r0_cnt", 32'(wb_count), 32'd0);
    cycle();
    chk("r0_we", 32'(Write_enable), 32'd0);
    chk("r0_hit", 32'(Bypass_hit1), 32'd0);

    // Bypass priority
    rf_stall = 1'b1;
    Read_register1 = 5'd7; Read_register2 = 5'd8;
    wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hA;
    cycle();
    wb_data = 32'hB;
    cycle();
    wb_valid = 1'b0;
    chk("byp_hit1", 32'(Bypass_hit1), 32'd1);
    chk("byp_data1", Bypass_data1, 32'hB);
    chk("byp_hit2", 32'(Bypass_hit2), 32'd0);
    chk("byp_data2", Bypass_data2, 32'd0);

    // Simultaneous push/pop at count 2
    rf_stall = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hC;
    cycle();
    chk("pp_cnt", 32'(wb_count), 32'd2);
    wb_valid = 1'b0;
    repeat (4) cycle();

    // Reset mid-operation: 3 queued plus output stage busy
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_reg = 5'(10 + i); wb_data = 32'(100 + i);
      cycle();
    end
    wb_valid = 1'b0;
    rf_stall = 1'b0;
    cycle();
    rf_stall = 1'b1;
    Read_register1 = 5'd12;
    chk("mid_we", 32'(Write_enable), 32'd1);
    chk("mid_cnt", 32'(wb_count), 32'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst2_we", 32'(Write_enable), 32'd0);
    chk("rst2_cnt", 32'(wb_count), 32'd0);
    chk("rst2_hit", 32'(Bypass_hit1), 32'd0);
    chk("rst2_ready", 32'(wb_ready), 32'd1);
    rf_stall = 1'b0;

    // Random traffic, many pointer wraps
    for (int n = 0; n < 400; n++) begin
      wb_valid = ($urandom_range(0, 9) < 7);
      wb_reg = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      wb_data = $urandom;
      rf_stall = ($urandom_range(0, 9) < 3);
      Read_register1 = 5'($urandom_range(0, 6));
      Read_register2 = 5'($urandom_range(0, 6));
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    wb_valid = 1'b0;
    rf_stall = 1'b0;
    repeat (6) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side companion to the register file's read ports: accepts register write-back requests from the execute stage over a valid/ready handshake, buffers them in an in-order queue, and drains one entry per cycle onto the register file write port. It also exposes a bypass lookup so the read side can get values that are queued or in flight but not yet committed to the register array. It sits between execute/write-back and the register file.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wb_valid  input  1  write-back request present
- wb_ready  output  1  queue can accept; equals (wb_count < DEPTH)
- wb_reg  input  5  destination register
- wb_data  input  32  value to write
- rf_stall  input  1  register file write port unavailable this cycle
- Write_enable  output  1  registered; commit Write_data to Write_register at next edge
- Write_register  output  5  registered write address
- Write_data  output  32  registered write data
- Read_register1  input  5  bypass lookup address, port 1
- Read_register2  input  5  bypass lookup address, port 2
- Bypass_hit1  output  1  combinational; pending write to Read_register1 exists
- Bypass_data1  output  32  youngest pending value for Read_register1; 0 when no hit
- Bypass_hit2  output  1  as port 1
- Bypass_data2  output  32  as port 1
- wb_count  output  $clog2(DEPTH)+1  current queue occupancy

## Operation
- Accept: wb_valid && wb_ready at a rising edge. If wb_reg != 0, push {wb_reg, wb_data} at tail. If wb_reg == 0, request is accepted (handshake completes) but discarded; no push.
- Drain: at any edge with wb_count > 0 and !rf_stall, load the head into Write_register/Write_data, set Write_enable=1, and pop. Otherwise Write_enable=0 at that edge; Write_register/Write_data hold their values.
- Strict FIFO order; there is no write merging or reordering.
- Simultaneous push and pop in one edge: both take effect; wb_count unchanged. Full queue: wb_ready=0, so no push; a pop in the same edge frees space for the next cycle only (wb_ready does not look ahead).
- Pointers wrap modulo DEPTH. wb_count ranges 0..DEPTH.
- Bypass lookup, per port, is purely combinational over the current state:
  - Search all valid queue entries plus the output stage (Write_enable=1 entry).
  - Priority: youngest queue entry (closest to tail), then older queue entries, then the output stage.
  - Address 0 never hits.
  - The incoming wb_* request in the same cycle is not searched.
- rf_stall only blocks the drain. Accepts continue until the queue is full.

## Timing
- Reset (synchronous, at the edge with reset=1):
  - wb_count=0, pointers=0.
  - Write_enable=0, Write_register=0, Write_data=0.
  - All queue entries invalid. Bypass_hit*=0, Bypass_data*=0. wb_ready=1 in the following cycle.
  - Queued and in-flight writes are discarded, with no Write_enable.
  - Reset has priority over concurrent accept/drain.
- Latency with an empty queue and no stall:
  - Request accepted at edge k.
  - Write_enable=1 during cycle k+1→k+2.
  - Register file commits at edge k+2.
- Throughput: one accept and one drain per cycle sustained; wb_ready stays 1 when rates match.
- Bypass visibility: a value hits from the cycle after its accept edge until the cycle in which its Write_enable is high, inclusive. It stops hitting once committed, unless a younger write to the same register is pending.

## Test plan
- Reset then single write: wb_reg=5, wb_data=32'hDEADBEEF accepted at edge 1 → Write_enable=1, Write_register=5, Write_data=32'hDEADBEEF in cycle after edge 2; wb_count returns to 0.
- Fill with rf_stall=1: push regs 1..4 (data 32'h1..32'h4) → wb_count=4, wb_ready=0, 5th request held off. Release stall → four consecutive Write_enable pulses in order 1,2,3,4.
- Register 0: request wb_reg=0, data 32'hFFFFFFFF → handshake completes, wb_count stays 0, no Write_enable, Bypass_hit1=0 for Read_register1=0.
- Bypass priority with rf_stall=1: queue reg 7 = 32'hA, then reg 7 = 32'hB → Read_register1=7 gives Bypass_hit1=1, Bypass_data1=32'hB. Read_register2=8 gives Bypass_hit2=0, data 0.
- Simultaneous push/pop at wb_count=2 → wb_count stays 2. Pointer wrap across ≥2·DEPTH transactions preserves order and data.
- Reset mid-operation: 3 queued entries plus Write_enable=1, assert reset one cycle → next cycle Write_enable=0, wb_count=0, no bypass hits, wb_ready=1.
